// File: rtl/tlu_trigger_fifo.sv
// tlu_trigger_fifo: DEPTH-entry first-word-fall-through trigger buffer between
// the TLU serial-to-parallel receiver and the readout arbiter, all in BUS_CLK.
// The presented word is the oldest stored entry. It is shown as {1'b1, zero-extended payload}.
// FILL_LEVEL counts every stored word, including the presented one.
// Optional feature macro: TLU_FIFO_LOST_COUNT_EN. When it is defined, the
// saturating LOST_COUNT counter and CLEAR_LOST are built. When it is undefined,
// LOST_COUNT is tied to 0 and full-buffer drops are silent.
module tlu_trigger_fifo #(
  parameter int DATA_WIDTH      = 31,
  parameter int DEPTH           = 16,
  parameter int NEAR_FULL_LEVEL = 14
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST_N,
  input  logic [DATA_WIDTH-1:0]   IN_DATA,
  input  logic                    IN_VALID,
  output logic                    IN_ACCEPTED,
  input  logic                    FIFO_READ,
  output logic                    FIFO_EMPTY,
  output logic [31:0]             FIFO_DATA,
  output logic                    FIFO_NEAR_FULL,
  output logic [$clog2(DEPTH):0]  FILL_LEVEL,
  input  logic                    CLEAR_LOST,
  output logic [7:0]              LOST_COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    accepted_q, accepted_d;
  logic                    near_full_q, near_full_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    rd_fire;
  logic                    wr_fire;
  logic                    drop;
  logic                    full;
  logic [30:0]             payload;

  // A read only counts while a word is presented. A read in the same cycle
  // frees a slot, so a write into a full buffer is still accepted.
  assign full    = (count_q == CW'(DEPTH));
  assign rd_fire = FIFO_READ && (state_q == ST_VALID);
  assign wr_fire = IN_VALID && (!full || rd_fire);
  assign drop    = IN_VALID && !wr_fire;

  // Output state register: EMPTY vs VALID presented word
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a write fills an empty output; the last word leaving without a refill empties it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (wr_fire) begin
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (rd_fire && (count_q == CW'(1)) && !wr_fire) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Output decode: presented word is the oldest entry, forced to 0 when empty
  always_comb begin
    payload                 = '0;
    payload[DATA_WIDTH-1:0] = mem_q[rd_ptr_q];
    FIFO_EMPTY              = (state_q == ST_EMPTY);
    FIFO_DATA               = '0;
    if (state_q == ST_VALID) begin
      FIFO_DATA = {1'b1, payload};
    end
  end

  // Pointer, occupancy and flag next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    accepted_d = wr_fire;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Computed from the next occupancy, so the registered flag lines up with FILL_LEVEL
    near_full_d = (count_d >= CW'(NEAR_FULL_LEVEL));
  end

  // Control registers; reset discards all stored words by rewinding the pointers
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      accepted_q  <= 1'b0;
      near_full_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      accepted_q  <= accepted_d;
      near_full_q <= near_full_d;
    end
  end

  // Storage array; it holds data only, so it is not reset
  always_ff @(posedge BUS_CLK) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= IN_DATA;
    end
  end

  assign IN_ACCEPTED    = accepted_q;
  assign FILL_LEVEL     = count_q;
  assign FIFO_NEAR_FULL = near_full_q;

`ifdef TLU_FIFO_LOST_COUNT_EN
  logic [7:0] lost_q, lost_d;

  // Lost-trigger count: clear wins over a same-cycle drop, and the count saturates at 255
  always_comb begin
    lost_d = lost_q;
    if (CLEAR_LOST) begin
      lost_d = '0;
    end else if (drop && (lost_q != 8'hFF)) begin
      lost_d = lost_q + 1'b1;
    end
  end

  // Lost-trigger counter register
  always_ff @(posedge BUS_CLK) begin
    if (!BUS_RST_N) begin
      lost_q <= '0;
    end else begin
      lost_q <= lost_d;
    end
  end

  assign LOST_COUNT = lost_q;
`else
  // Counter not built: drops are silent and the clear input has no effect
  logic unused_lost;
  assign unused_lost = CLEAR_LOST ^ drop;
  assign LOST_COUNT  = 8'd0;
`endif

endmodule

// File: tb/tb_tlu_trigger_fifo.sv
// Directed testbench for tlu_trigger_fifo.
// It uses a DEPTH=16 instance for the main sequence and a DEPTH=4, 8-bit instance for pointer wrap.
module tb_tlu_trigger_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [30:0] d16;
  logic        v16, r16, c16;
  logic        acc16, emp16, nf16;
  logic [31:0] dat16;
  logic [4:0]  fill16;
  logic [7:0]  lost16;

  logic [7:0]  d4;
  logic        v4, r4, c4;
  logic        acc4, emp4, nf4;
  logic [31:0] dat4;
  logic [2:0]  fill4;
  logic [7:0]  lost4;

  int checks   = 0;
  int failures = 0;
  int lost_m   = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  tlu_trigger_fifo u16 (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .IN_DATA(d16), .IN_VALID(v16),
    .IN_ACCEPTED(acc16), .FIFO_READ(r16), .FIFO_EMPTY(emp16), .FIFO_DATA(dat16),
    .FIFO_NEAR_FULL(nf16), .FILL_LEVEL(fill16), .CLEAR_LOST(c16), .LOST_COUNT(lost16)
  );

  tlu_trigger_fifo #(.DATA_WIDTH(8), .DEPTH(4), .NEAR_FULL_LEVEL(3)) u4 (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .IN_DATA(d4), .IN_VALID(v4),
    .IN_ACCEPTED(acc4), .FIFO_READ(r4), .FIFO_EMPTY(emp4), .FIFO_DATA(dat4),
    .FIFO_NEAR_FULL(nf4), .FILL_LEVEL(fill4), .CLEAR_LOST(c4), .LOST_COUNT(lost4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lost_inc(input int v);
`ifdef TLU_FIFO_LOST_COUNT_EN
    return (v < 255) ? v + 1 : 255;
`else
    return 0;
`endif
  endfunction

  initial begin
    d16 = '0; v16 = 0; r16 = 0; c16 = 0;
    d4  = '0; v4  = 0; r4  = 0; c4  = 0;

    // reset values
    step(); step();
    chk("rst_empty", emp16, 1);
    chk("rst_data", dat16, 0);
    chk("rst_acc", acc16, 0);
    chk("rst_nf", nf16, 0);
    chk("rst_fill", fill16, 0);
    chk("rst_lost", lost16, 0);
    rst_n = 1;
    step();

    // single write then read
    v16 = 1; d16 = 31'h0000_0005; step(); v16 = 0;
    chk("w1_empty", emp16, 0);
    chk("w1_data", dat16, 32'h8000_0005);
    chk("w1_acc", acc16, 1);
    chk("w1_fill", fill16, 1);
    step();
    chk("w1_acc_pulse", acc16, 0);
    r16 = 1; step(); r16 = 0;
    chk("r1_empty", emp16, 1);
    chk("r1_data", dat16, 0);
    chk("r1_fill", fill16, 0);

    // fill 1..16, near-full from the 14th word
    v16 = 1;
    for (int i = 1; i <= 16; i++) begin
      d16 = 31'(i); step();
      chk("fill_acc", acc16, 1);
      chk("fill_level", fill16, 32'(i));
      chk("fill_nf", nf16, (i >= 14) ? 1 : 0);
    end
    // 17th word into a full buffer is dropped
    d16 = 31'd17; step(); v16 = 0;
    lost_m = lost_inc(lost_m);
    chk("drop_acc", acc16, 0);
    chk("drop_fill", fill16, 16);
    chk("drop_lost", lost16, 32'(lost_m));

    // full buffer, simultaneous read and write
    v16 = 1; r16 = 1; d16 = 31'd17; step(); v16 = 0; r16 = 0;
    chk("fullrw_acc", acc16, 1);
    chk("fullrw_fill", fill16, 16);
    chk("fullrw_data", dat16, 32'h8000_0002);
    chk("fullrw_lost", lost16, 32'(lost_m));

    // drain: 2..17 in order
    for (int i = 2; i <= 17; i++) begin
      chk("drain_data", dat16, 32'h8000_0000 | 32'(i));
      r16 = 1; step(); r16 = 0;
    end
    chk("drain_empty", emp16, 1);
    chk("drain_fill", fill16, 0);
    chk("drain_nf", nf16, 0);

    // FILL_LEVEL=1, read A while writing B
    v16 = 1; d16 = 31'h0A; step();
    chk("a_data", dat16, 32'h8000_000A);
    d16 = 31'h0B; r16 = 1; step(); v16 = 0; r16 = 0;
    chk("b_empty", emp16, 0);
    chk("b_data", dat16, 32'h8000_000B);
    chk("b_fill", fill16, 1);
    chk("b_acc", acc16, 1);
    r16 = 1; step(); r16 = 0;
    chk("b_read_empty", emp16, 1);

    // read while empty is ignored
    r16 = 1; step(); r16 = 0;
    chk("rd_empty_empty", emp16, 1);
    chk("rd_empty_fill", fill16, 0);
    chk("rd_empty_data", dat16, 0);

    // fill with full-width payloads, then 300 drops
    v16 = 1;
    for (int i = 0; i < 16; i++) begin
      d16 = 31'h7FFF_FFF0 | 31'(i); step();
    end
    chk("wide_data", dat16, 32'hFFFF_FFF0);
    for (int i = 0; i < 300; i++) begin
      d16 = 31'h4000_0000 | 31'(i); step();
      lost_m = lost_inc(lost_m);
    end
    v16 = 0;
    chk("sat_lost", lost16, 32'(lost_m));
    chk("sat_fill", fill16, 16);
    chk("sat_acc", acc16, 0);
    // clear wins over a same-cycle drop
    c16 = 1; v16 = 1; step(); c16 = 0; v16 = 0;
    lost_m = 0;
    chk("clr_lost", lost16, 0);
    step();
    chk("clr_hold", lost16, 0);

    // reset with 5 words stored, write during the reset cycle
    rst_n = 0; step(); rst_n = 1;
    v16 = 1;
    for (int i = 0; i < 5; i++) begin
      d16 = 31'h20 + 31'(i); step();
    end
    v16 = 0;
    chk("pre_rst_fill", fill16, 5);
    rst_n = 0; v16 = 1; d16 = 31'h55; step(); rst_n = 1; v16 = 0;
    chk("mid_rst_empty", emp16, 1);
    chk("mid_rst_fill", fill16, 0);
    chk("mid_rst_acc", acc16, 0);
    chk("mid_rst_data", dat16, 0);
    v16 = 1; d16 = 31'h77; step(); v16 = 0;
    chk("post_rst_data", dat16, 32'h8000_0077);
    chk("post_rst_fill", fill16, 1);
    r16 = 1; step(); r16 = 0;
    chk("post_rst_empty", emp16, 1);

    // DEPTH=4 pointer wrap: preload 3, then 40 read/write pairs
    v4 = 1;
    for (int i = 0; i < 3; i++) begin
      d4 = 8'(8'hA0 + i); q.push_back(d4); step();
    end
    v4 = 0;
    chk("d4_fill", fill4, 3);
    chk("d4_nf", nf4, 1);
    chk("d4_head", dat4, {1'b1, 23'd0, q[0]});
    for (int k = 0; k < 40; k++) begin
      d4 = 8'(8'hC0 + k); v4 = 1; r4 = 1; step();
      void'(q.pop_front());
      q.push_back(d4);
      chk("wrap_data", dat4, {1'b1, 23'd0, q[0]});
      chk("wrap_fill", fill4, 3);
      chk("wrap_acc", acc4, 1);
    end
    v4 = 0; r4 = 0;
    while (q.size() > 0) begin
      chk("wrap_drain", dat4, {1'b1, 23'd0, q[0]});
      r4 = 1; step(); r4 = 0;
      void'(q.pop_front());
    end
    chk("wrap_empty", emp4, 1);
    chk("wrap_lost", lost4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
